// File: rtl/fu_issue_arb_pkg.sv
// rtl/fu_issue_arb_pkg.sv - shared types and defaults for the FU issue arbiter
package fu_issue_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fu_arb_state_t;

    localparam int FU_ARB_NUM_REQ = 8;
    localparam int FU_ARB_TAG_W   = 6;
    localparam int FU_ARB_STALL_W = 16;

endpackage

// File: rtl/fu_issue_arb_ps_rr_tree.sv
// rtl/fu_issue_arb_ps_rr_tree.sv - rotating-priority selector tree built from 2-input cells
module ps_rr_tree #(
    parameter int NUM_REQ = 8
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // One 2-input selector cell: the lower-index child wins, request-up is the OR.
    function automatic logic [IDX_W:0] sel_cell(
        input logic             l_any,
        input logic [IDX_W-1:0] l_idx,
        input logic             r_any,
        input logic [IDX_W-1:0] r_idx
    );
        return {l_any | r_any, (l_any ? l_idx : r_idx)};
    endfunction

    // Heap-ordered tree (node n has children 2n, 2n+1). Two request classes
    // travel up the tree: requests at or above ptr, and all requests. The
    // first class wins if non-empty, which realises the rotation from ptr.
    function automatic logic [IDX_W:0] rr_tree(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [2*NUM_REQ-1:0] any_all;
        logic [2*NUM_REQ-1:0] any_hi;
        logic [IDX_W-1:0]     idx_all [2*NUM_REQ];
        logic [IDX_W-1:0]     idx_hi  [2*NUM_REQ];
        logic [IDX_W:0]       c_all;
        logic [IDX_W:0]       c_hi;
        any_all = '0;
        any_hi  = '0;
        for (int n = 0; n < 2*NUM_REQ; n++) begin
            idx_all[n] = '0;
            idx_hi[n]  = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            any_all[NUM_REQ+i] = req[i];
            any_hi[NUM_REQ+i]  = req[i] && (i >= int'(ptr));
            idx_all[NUM_REQ+i] = IDX_W'(i);
            idx_hi[NUM_REQ+i]  = IDX_W'(i);
        end
        for (int n = NUM_REQ-1; n >= 1; n--) begin
            c_all = sel_cell(any_all[2*n], idx_all[2*n], any_all[2*n+1], idx_all[2*n+1]);
            c_hi  = sel_cell(any_hi[2*n],  idx_hi[2*n],  any_hi[2*n+1],  idx_hi[2*n+1]);
            any_all[n] = c_all[IDX_W];
            idx_all[n] = c_all[IDX_W-1:0];
            any_hi[n]  = c_hi[IDX_W];
            idx_hi[n]  = c_hi[IDX_W-1:0];
        end
        return {any_all[1], (any_hi[1] ? idx_hi[1] : idx_all[1])};
    endfunction

    logic [IDX_W:0] tree_res;

    // Evaluate the tree and expand the winner index to a one-hot grant.
    always_comb begin
        tree_res = rr_tree(req_i, ptr_i);
        valid_o  = tree_res[IDX_W];
        idx_o    = tree_res[IDX_W-1:0];
        gnt_o    = '0;
        if (tree_res[IDX_W]) begin
            gnt_o[tree_res[IDX_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/fu_issue_arb.sv
// rtl/fu_issue_arb.sv - round-robin issue arbiter for a shared multi-cycle FU (option: FU_ARB_STALL_CNT_EN)
module fu_issue_arb
    import fu_issue_arb_pkg::*;
#(
    parameter int NUM_REQ = FU_ARB_NUM_REQ,
    parameter int TAG_W   = FU_ARB_TAG_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
    input  logic                       fu_ready_i,
    input  logic                       fu_done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       issue_valid_o,
    output logic [TAG_W-1:0]           issue_tag_o,
    output logic                       busy_o
`ifdef FU_ARB_STALL_CNT_EN
    ,
    output logic [FU_ARB_STALL_W-1:0]  stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    fu_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               issue_valid_q, issue_valid_d;
    logic [TAG_W-1:0]   issue_tag_q, issue_tag_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   arb_ptr;
    logic [NUM_REQ-1:0] tree_gnt;
    logic [IDX_W-1:0]   tree_idx;
    logic               tree_valid;
    logic               arb_win;

    // A completing op moves the pointer past its winner; a back-to-back
    // arbitration in that same cycle must already see the moved pointer.
    always_comb begin
        arb_ptr = ptr_q;
        if (state_q == WAIT && fu_done_i) begin
            arb_ptr = win_q + IDX_W'(1);
        end
    end

    ps_rr_tree #(
        .NUM_REQ (NUM_REQ)
    ) u_tree (
        .req_i   (req_i),
        .ptr_i   (arb_ptr),
        .gnt_o   (tree_gnt),
        .idx_o   (tree_idx),
        .valid_o (tree_valid)
    );

    // FSM next state, pointer update and arbitration-win decision.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = 1'b0;
        arb_win = 1'b0;
        case (state_q)
            IDLE: begin
                if (tree_valid && fu_ready_i) begin
                    arb_win = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy_d = 1'b1;
                if (fu_done_i) begin
                    ptr_d  = arb_ptr;
                    busy_d = 1'b0;
                    if (tree_valid && fu_ready_i) begin
                        arb_win = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register loads: grant and tag are captured only on a win.
    always_comb begin
        gnt_d         = '0;
        issue_valid_d = arb_win;
        issue_tag_d   = issue_tag_q;
        win_d         = win_q;
        if (arb_win) begin
            gnt_d       = tree_gnt;
            issue_tag_d = req_tag_i[int'(tree_idx)*TAG_W +: TAG_W];
            win_d       = tree_idx;
        end
    end

    // State, pointer and output registers; reset abandons any in-flight op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            gnt_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_tag_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            gnt_q         <= gnt_d;
            issue_valid_q <= issue_valid_d;
            issue_tag_q   <= issue_tag_d;
            busy_q        <= busy_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign issue_valid_o = issue_valid_q;
    assign issue_tag_o   = issue_tag_q;
    assign busy_o        = busy_q;

`ifdef FU_ARB_STALL_CNT_EN
    logic [FU_ARB_STALL_W-1:0] stall_cnt_q;

    // Count cycles where someone is waiting but nobody wins; saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (tree_valid && !arb_win && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + FU_ARB_STALL_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fu_issue_arb.sv
// tb/tb_fu_issue_arb.sv - scoreboard bench for fu_issue_arb (optional FU_ARB_STALL_CNT_EN)
module tb_fu_issue_arb;

    typedef struct {
        logic [7:0] gnt;
        logic [5:0] tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [47:0] req_tag;
    logic        fu_ready;
    logic        fu_done;
    logic [7:0]  gnt;
    logic        issue_valid;
    logic [5:0]  issue_tag;
    logic        busy;
`ifdef FU_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    fu_issue_arb #(
        .NUM_REQ (8),
        .TAG_W   (6)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .req_tag_i     (req_tag),
        .fu_ready_i    (fu_ready),
        .fu_done_i     (fu_done),
        .gnt_o         (gnt),
        .issue_valid_o (issue_valid),
        .issue_tag_o   (issue_tag),
        .busy_o        (busy)
`ifdef FU_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] tag_of(input int i);
        return 6'(33 + 3*i);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input int bit_i);
        exp_t e;
        e.gnt = 8'd0;
        e.gnt[bit_i] = 1'b1;
        e.tag = tag_of(bit_i);
        sb.push_back(e);
    endtask

    // Scoreboard: every issue pops the oldest expected grant; no issue means no grant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (issue_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_issue", {24'd0, gnt}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_gnt", {24'd0, gnt}, {24'd0, e.gnt});
                    chk("sb_tag", {26'd0, issue_tag}, {26'd0, e.tag});
                end
            end else if (gnt !== 8'd0) begin
                chk("gnt_without_issue", {24'd0, gnt}, 32'd0);
            end
        end
    end

    initial begin
        int issues;
        int since;
        rst_n    = 1'b0;
        req      = 8'd0;
        fu_ready = 1'b0;
        fu_done  = 1'b0;
        for (int i = 0; i < 8; i++) req_tag[i*6 +: 6] = tag_of(i);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", {24'd0, gnt}, 32'd0);
        chk("rst_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_tag", {26'd0, issue_tag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Single requester on bit 2
        @(negedge clk);
        req = 8'h04; fu_ready = 1'b1; push(2);
        @(negedge clk);
        chk("single_issue_busy", {31'd0, busy}, 32'd0);
        req = 8'h00;
        @(negedge clk);
        chk("single_wait_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("single_wait_busy2", {31'd0, busy}, 32'd1);
        fu_done = 1'b1;
        @(negedge clk);
        chk("single_idle_busy", {31'd0, busy}, 32'd0);
        fu_done = 1'b0;
        // Pointer should now be 3: bit 3 beats bits 0 and 1
        req = 8'b0000_1011; push(3);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        fu_done = 1'b1;
        @(negedge clk);
        // Spurious fu_done in IDLE with no requests
        @(negedge clk);
        chk("spurious_valid", {31'd0, issue_valid}, 32'd0);
        chk("spurious_busy", {31'd0, busy}, 32'd0);
        fu_done = 1'b0;

        // fu_ready low for 5 cycles with req on bit 4
        fu_ready = 1'b0; req = 8'h10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("notready_valid", {31'd0, issue_valid}, 32'd0);
        end
`ifdef FU_ARB_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
        fu_ready = 1'b1; push(4);
        @(negedge clk);
        chk("ready_issue", {31'd0, issue_valid}, 32'd1);
        req = 8'h00;
        @(negedge clk);
        fu_done = 1'b1;
        @(negedge clk);
        fu_done = 1'b0;

        // Full contention from reset: expect 0..7 then wrap to 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req = 8'hFF; fu_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(k);
        push(0);
        issues = 0;
        since  = -1;
        for (int cyc = 0; cyc < 200 && issues < 9; cyc++) begin
            @(negedge clk);
            fu_done = 1'b0;
            if (issue_valid) begin
                issues++;
                since = 0;
                chk("cont_issue_busy", {31'd0, busy}, 32'd0);
            end else if (since >= 0) begin
                since++;
                chk("cont_wait_busy", {31'd0, busy}, 32'd1);
                if (since == 3) fu_done = 1'b1;
            end
        end
        chk("cont_issue_count", 32'(issues), 32'd9);
        req = 8'h00;

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_gnt", {24'd0, gnt}, 32'd0);
        chk("async_rst_tag", {26'd0, issue_tag}, 32'd0);
        chk("async_rst_valid", {31'd0, issue_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req = 8'h81; push(0);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        // Back-to-back into winner 6
        fu_done = 1'b1; req = 8'h40; push(6);
        @(negedge clk);
        chk("b2b6_busy", {31'd0, busy}, 32'd0);
        fu_done = 1'b0; req = 8'h00;
        @(negedge clk);
        chk("b2b6_wait_busy", {31'd0, busy}, 32'd1);
        // Completion of winner 6 with bits 7 and 0 pending: ptr=7 picks bit 7
        fu_done = 1'b1; req = 8'h81; push(7);
        @(negedge clk);
        chk("b2b7_busy", {31'd0, busy}, 32'd0);
        fu_done = 1'b0; req = 8'h00;
        @(negedge clk);
        chk("b2b7_wait_busy", {31'd0, busy}, 32'd1);
        fu_done = 1'b1;
        @(negedge clk);
        fu_done = 1'b0;
        chk("final_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
